// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus per-bit debounce FSM for raw board switches.
// Optional per-bit rise/fall pulses are built when SWITCH_DEBOUNCE_EDGE_EN is defined.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | synchronised level matches sw_clean[i]; counter held at 0
// COUNT | level differs from sw_clean[i]; counter advances each cycle
module switch_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int CNT_W           = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic             changed,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  // Terminal count: the toggle fires on the edge where the counter already holds this.
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] mismatch;
  logic [WIDTH-1:0] toggle;

  state_t           state_q [WIDTH];
  state_t           state_d [WIDTH];
  logic [CNT_W-1:0] cnt_q   [WIDTH];
  logic [CNT_W-1:0] cnt_d   [WIDTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
    end
  end

  assign mismatch = s2 ^ sw_clean;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = '0;
      toggle[i]  = 1'b0;
      unique case (state_q[i])
        IDLE: begin
          if (mismatch[i]) begin
            if (CNT_TC == '0) begin
              toggle[i] = 1'b1;
            end else begin
              state_d[i] = COUNT;
              cnt_d[i]   = CNT_W'(1);
            end
          end
        end
        COUNT: begin
          if (!mismatch[i]) begin
            state_d[i] = IDLE;
          end else if (cnt_q[i] == CNT_TC) begin
            toggle[i]  = 1'b1;
            state_d[i] = IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  // A reset edge wins over a count that would have completed on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      sw_clean <= '0;
      changed  <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      sw_clean <= sw_clean ^ toggle;
      changed  <= |toggle;
    end
  end

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= toggle & ~sw_clean;
      fall_q <= toggle & sw_clean;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer: stimulus pushes expected updates,
// a negedge monitor pops them when changed fires and checks quiet cycles otherwise.
module tb_switch_debouncer;

  localparam int W = 4;
  localparam int D = 4;

  typedef struct {
    int         cyc;
    logic [3:0] clean;
    logic [3:0] rise;
    logic [3:0] fall;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] sw_clean;
  logic         changed;
  logic [W-1:0] rise;
  logic [W-1:0] fall;

  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  exp_t q[$];
  exp_t mon_e;

  switch_debouncer #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D),
    .CNT_W(24)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sw_raw(sw_raw),
    .sw_clean(sw_clean),
    .changed(changed),
    .rise(rise),
    .fall(fall)
  );

  always #10 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h, required %0h", name, cyc, act, req);
    end
  endtask

  task automatic push(input int c, input logic [3:0] cl, input logic [3:0] r, input logic [3:0] f);
    exp_t e;
    e.cyc   = c;
    e.clean = cl;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    e.rise  = r;
    e.fall  = f;
`else
    e.rise  = 4'b0000;
    e.fall  = 4'b0000;
`endif
    q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() > 0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout with %0d expected updates outstanding, required 0", name, q.size());
      q.delete();
    end
    repeat (3) @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        mon_e = q.pop_front();
        check("changed_pulse", 32'(changed), 32'd1);
        check("sw_clean", 32'(sw_clean), 32'(mon_e.clean));
        check("rise", 32'(rise), 32'(mon_e.rise));
        check("fall", 32'(fall), 32'(mon_e.fall));
      end else begin
        check("quiet_changed_rise_fall", 32'({changed, rise, fall}), 32'd0);
      end
    end
  end

  initial begin
    int k;
    int bounce [6];
    bounce = '{1, 0, 1, 1, 0, 1};

    // Reset held for 3 edges with all switches high
    reset  = 1'b1;
    sw_raw = 4'b1111;
    @(negedge clock);
    mon_en = 1'b1;
    check("reset_sw_clean", 32'(sw_clean), 32'd0);
    check("reset_changed", 32'(changed), 32'd0);
    repeat (2) @(negedge clock);
    check("reset_hold_sw_clean", 32'(sw_clean), 32'd0);
    reset = 1'b0;
    push(cyc + 6, 4'b1111, 4'b1111, 4'b0000);
    drain("reset_release");

    // Fall of bit 3
    sw_raw = 4'b0111;
    push(cyc + 6, 4'b0111, 4'b0000, 4'b1000);
    drain("fall_bit3");

    sw_raw = 4'b0000;
    push(cyc + 6, 4'b0000, 4'b0000, 4'b0111);
    drain("fall_rest");

    // Clean step, with explicit strobe-length check one edge later
    sw_raw = 4'b0001;
    k = cyc;
    push(k + 6, 4'b0001, 4'b0001, 4'b0000);
    repeat (7) @(negedge clock);
    check("clean_step_changed_after", 32'(changed), 32'd0);
    check("clean_step_sw_clean_after", 32'(sw_clean), 32'b0001);
    drain("clean_step");

    // Bounce on bit 2: runs shorter than the debounce window must not pass
    for (int i = 0; i < 6; i++) begin
      sw_raw[2] = bounce[i][0];
      if (i == 5) push(cyc + 6, 4'b0101, 4'b0100, 4'b0000);
      @(negedge clock);
    end
    check("bounce_sw_clean_mid", 32'(sw_clean), 32'b0001);
    drain("bounce");

    sw_raw = 4'b0000;
    push(cyc + 6, 4'b0000, 4'b0000, 4'b0101);
    drain("back_to_zero");

    // Two bits in one cycle
    sw_raw = 4'b1010;
    push(cyc + 6, 4'b1010, 4'b1010, 4'b0000);
    drain("simultaneous");

    // Reset clears outputs without a changed pulse
    reset  = 1'b1;
    sw_raw = 4'b0000;
    @(negedge clock);
    check("reset_clears_sw_clean", 32'(sw_clean), 32'd0);
    reset = 1'b0;
    repeat (6) @(negedge clock);

    // Reset mid-count restarts the full latency
    sw_raw[0] = 1'b1;
    k = cyc;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midcount_reset_sw_clean", 32'(sw_clean), 32'd0);
    reset = 1'b0;
    push(k + 10, 4'b0001, 4'b0001, 4'b0000);
    drain("reset_midcount");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Synchronises and debounces the raw board switch inputs before they reach the SCIC `switches` port. Each bit passes through a two-flop synchroniser, then a per-bit counter requires the synchronised level to hold for `DEBOUNCE_CYCLES` consecutive clocks before the registered output follows it. A one-cycle `changed` strobe marks every output update, so the processor-side logic can sample new switch values without polling.

## Interface
- `WIDTH`, default 4: number of switch bits.
- `DEBOUNCE_CYCLES`, default 1250000: consecutive stable cycles required, 10 ms at 125 MHz. Legal range is 1 to 2^24−1.
- `CNT_W`, default 24: counter width. Must satisfy 2^CNT_W > `DEBOUNCE_CYCLES`.

Ports:
- `clock`  in  1: single clock. All state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `sw_raw`  in  WIDTH: asynchronous raw switch levels.
- `sw_clean`  out  WIDTH: debounced, registered switch levels. Connects to SCIC `switches`.
- `changed`  out  1: one-cycle pulse in the cycle when any `sw_clean` bit changes.
- `rise`  out  WIDTH: per-bit 0→1 pulse. Only active under the macro in Configuration.
- `fall`  out  WIDTH: per-bit 1→0 pulse. Only active under the macro in Configuration.

## Operation
- Synchroniser: `s1 <= sw_raw`, `s2 <= s1`, per bit. There is no other combinational path from `sw_raw`.
- Each bit has an independent FSM with two states:
  - IDLE: `s2 == sw_clean[i]`. The counter is held at 0.
  - COUNT: `s2 != sw_clean[i]`. The counter increments every cycle.
    - If the counter equals `DEBOUNCE_CYCLES−1` while the mismatch persists, `sw_clean[i]` toggles, the counter clears, and the FSM returns to IDLE.
    - If `s2` equals `sw_clean[i]` on any edge (a bounce back), the counter clears to 0 and the FSM returns to IDLE. Partial counts are never retained.
- `changed` is registered and equals the OR over bits of "toggle this edge". It is high for exactly one cycle per update edge. Several bits toggling on the same edge produce one pulse.
- The counter never wraps. It can only reach `DEBOUNCE_CYCLES−1` before clearing.
- Bits are fully independent. One bit bouncing does not affect the count of another bit.
- Reset, including reset asserted mid-count, clears `s1`, `s2`, every counter, `sw_clean`, `changed`, `rise` and `fall` to 0 on the next edge. No toggle occurs on a reset edge, even if a count would have completed.
- After reset release with `sw_raw` held high, the output reaches 1 through the normal debounce path. It does not load directly.

## Timing
- Reset values: `sw_clean`=0, `changed`=0, `rise`=0, `fall`=0.
- Latency, for `sw_raw[i]` changing and stable before edge E:
  - `s2` reflects the change after edge E+1.
  - `sw_clean[i]` and `changed` update at edge E+1+`DEBOUNCE_CYCLES`.
  - With `DEBOUNCE_CYCLES`=1, the update is at E+2.
- Minimum spacing between two toggles of the same bit is `DEBOUNCE_CYCLES` cycles.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles at `s2` never reaches `sw_clean`.
- There is no backpressure. The consumer must sample `sw_clean` in the `changed` cycle or later.

## Configuration
- Macro: `SWITCH_DEBOUNCE_EDGE_EN`.
- Defined:
  - `rise[i]` and `fall[i]` are registered one-cycle pulses in the same cycle as the `sw_clean[i]` toggle.
  - `rise[i]` marks a new value of 1; `fall[i]` marks a new value of 0.
  - `rise[i]` and `fall[i]` are never high together.
  - `changed` equals the OR of all `rise` and `fall` bits.
- Undefined:
  - `rise` and `fall` are tied to 0 and the edge registers are not built.
  - Ports remain present, so the top-level wiring is identical in both builds.
  - `changed` and `sw_clean` behave identically in both builds.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `WIDTH`=4 unless stated. The clock has a 20 ns period.
- Reset: hold `reset` for 3 edges with `sw_raw`=4'b1111, then release. Required: `sw_clean`=0 during reset. `sw_clean` becomes 4'b1111 exactly 5 edges after release, with a single `changed` pulse on that edge.
- Clean step: `sw_raw` goes 0→4'b0001 before edge E. Required: `sw_clean`=4'b0001 and `changed`=1 at edge E+5, and `changed`=0 at E+6. With the macro defined, `rise`=4'b0001 at edge E+5.
- Bounce: toggle `sw_raw[2]` as 1,0,1,1,0,1 on alternating single cycles, then hold at 1. Required: `sw_clean[2]` stays 0 until 5 edges after the final rise, then goes to 1. Exactly one `changed` pulse is produced.
- Simultaneous: `sw_raw` goes 4'b0000→4'b1010 in one cycle. Required: both bits update on the same edge with one `changed` pulse. With the macro defined, `rise`=4'b1010 and `fall`=0.
- Reset mid-count: `sw_raw[0]`=1, then assert `reset` 3 edges later for 1 edge. Required: `sw_clean`=0 and no `changed` pulse. The full 5-edge latency restarts from reset release.
- Fall edge with the macro defined: from `sw_clean`=4'b1111, drive `sw_raw`=4'b0111. Required: `fall`=4'b1000 and `rise`=0 at edge E+5. With the macro undefined, `rise` and `fall` stay 0 throughout.
